// File: rtl/lzd_normalize_48_pkg.sv
// Shared constants for the AWGN log-path normaliser (leading-zero detector + shifter).
package awgn_consts;

  localparam int SAMPLE_W   = 48;
  localparam int SHIFT_W    = 6;
  localparam int GROUP_W    = 8;
  localparam int NUM_GROUPS = SAMPLE_W / GROUP_W;
  localparam int LZ8_W      = 3;

  // Count reported for an all-zero sample; drives the shifter to a zero result.
  localparam logic [SHIFT_W-1:0] LZ_ALL_ZERO = 6'd48;

  // Per-group leading-zero counts, index 0 is the most significant group.
  typedef logic [NUM_GROUPS-1:0][LZ8_W-1:0] lz8_vec_t;

endpackage

// File: rtl/lzd_normalize_48_lzd8.sv
// Combinational 8-bit leading-zero count with a non-zero flag.
module lzd8
  import awgn_consts::*;
(
  input  logic [GROUP_W-1:0] data,
  output logic [LZ8_W-1:0]   lz,
  output logic               nz
);

  // Priority encode from the MSB; the count is a don't-care (7) when the group is zero.
  always_comb begin
    lz = 3'd7;
    nz = |data;
    casez (data)
      8'b1???????: lz = 3'd0;
      8'b01??????: lz = 3'd1;
      8'b001?????: lz = 3'd2;
      8'b0001????: lz = 3'd3;
      8'b00001???: lz = 3'd4;
      8'b000001??: lz = 3'd5;
      8'b0000001?: lz = 3'd6;
      default:     lz = 3'd7;
    endcase
  end

endmodule

// File: rtl/lzd_normalize_48.sv
// Two-stage pipelined leading-zero detector; sample and count leave aligned for the shifter.
module lzd_normalize_48
  import awgn_consts::*;
#(
  parameter int W = SAMPLE_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ce,
  input  logic               in_valid,
  input  logic [W-1:0]       num,
  output logic               out_valid,
  output logic [W-1:0]       num_q,
  output logic [SHIFT_W-1:0] shift_needed,
  output logic               all_zero
);

  logic [NUM_GROUPS-1:0] nz_c;
  lz8_vec_t              lz8_c;

  logic                  s1_valid;
  logic [W-1:0]          s1_num;
  logic [NUM_GROUPS-1:0] s1_nz;
  lz8_vec_t              s1_lz8;

  logic [SHIFT_W-1:0]    shift_c;
  logic                  zero_c;

  // Group k covers the k-th byte counted from the MSB, so lower k means more significant.
  for (genvar k = 0; k < NUM_GROUPS; k++) begin : g_grp
    lzd8 u_lzd8 (
      .data (num[W-1-GROUP_W*k -: GROUP_W]),
      .lz   (lz8_c[k]),
      .nz   (nz_c[k])
    );
  end

  // Stage 1 captures the per-group flags and counts alongside the raw sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_num   <= '0;
      s1_nz    <= '0;
      s1_lz8   <= '0;
    end else if (ce) begin
      s1_valid <= in_valid;
      s1_num   <= num;
      s1_nz    <= nz_c;
      s1_lz8   <= lz8_c;
    end
  end

  // Pick the most significant non-zero group; scanning upward lets lower k overwrite higher k.
  always_comb begin
    shift_c = LZ_ALL_ZERO;
    zero_c  = 1'b1;
    for (int k = NUM_GROUPS - 1; k >= 0; k--) begin
      if (s1_nz[k]) begin
        shift_c = SHIFT_W'(GROUP_W * k) + SHIFT_W'(s1_lz8[k]);
        zero_c  = 1'b0;
      end
    end
  end

  // Stage 2 registers the aligned sample, count and flags that feed the shifter directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      num_q        <= '0;
      shift_needed <= '0;
      all_zero     <= 1'b0;
    end else if (ce) begin
      out_valid    <= s1_valid;
      num_q        <= s1_num;
      shift_needed <= shift_c;
      all_zero     <= zero_c;
    end
  end

endmodule
